// File: rtl/dvs_event_fifo.sv
// dvs_event_fifo: first-word-fall-through FIFO for DVS address events.
// Events that arrive while it is full are dropped and counted.
package dvs_pkg;
  localparam int DVS_X_ADDR_BITS = 8;
  localparam int DVS_Y_ADDR_BITS = 8;
  localparam int TIMESTAMP_US_BITS = 32;
endpackage

module dvs_event_fifo import dvs_pkg::*; #(
  parameter int X_BITS = DVS_X_ADDR_BITS,
  parameter int Y_BITS = DVS_Y_ADDR_BITS,
  parameter int TS_BITS = TIMESTAMP_US_BITS,
  parameter int DEPTH = 16,
  parameter int DROP_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [X_BITS-1:0]          in_x,
  input  logic [Y_BITS-1:0]          in_y,
  input  logic [TS_BITS-1:0]         in_ts,
  input  logic                       in_pol,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [X_BITS-1:0]          out_x,
  output logic [Y_BITS-1:0]          out_y,
  output logic [TS_BITS-1:0]         out_ts,
  output logic                       out_pol,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic [DROP_BITS-1:0]       drop_count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = TS_BITS + 1 + Y_BITS + X_BITS;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic [DROP_BITS-1:0] drop_q, drop_d;
  logic ovf_q, ovf_d, push, pop, drop;
  assign out_valid = level_q != '0;
  assign full = level_q == LW'(DEPTH);
  assign level = level_q;
  assign drop_count = drop_q;
  assign overflow = ovf_q;
  assign {out_ts, out_pol, out_y, out_x} = mem_q[rd_q];
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  always_comb begin
    pop = out_valid & out_ready;
    push = in_valid & (~full | pop);
    drop = in_valid & full & ~pop;
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(push) - LW'(pop);
    drop_d = (drop & ~&drop_q) ? drop_q + DROP_BITS'(1) : drop_q;
    ovf_d = ovf_q | drop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      drop_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= {in_ts, in_pol, in_y, in_x};
  end
endmodule

// File: doc/dvs_event_fifo.md
DVS_EVENT_FIFO -- requirements
Module: dvs_event_fifo

Parameters
REQ-001 The module SHALL have parameter X_BITS, default DVS_X_ADDR_BITS, giving the event X address width.
REQ-002 The module SHALL have parameter Y_BITS, default DVS_Y_ADDR_BITS, giving the event Y address width.
REQ-003 The module SHALL have parameter TS_BITS, default TIMESTAMP_US_BITS, giving the event timestamp width in microseconds.
REQ-004 The module SHALL have parameter DEPTH, default 16, giving the entry count; it is a power of two and at least 2.
REQ-005 The module SHALL have parameter DROP_BITS, default 16, giving the dropped-event counter width.

Interface
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The module SHALL have port in_valid, input, 1 bit: one-cycle pulse marking a new event (the receiver new_event).
REQ-009 The module SHALL have ports in_x (X_BITS), in_y (Y_BITS), in_ts (TS_BITS) and in_pol (1 bit), all inputs, carrying the event fields and valid when in_valid=1.
REQ-010 The module SHALL have port out_valid, output, 1 bit: the head entry is present.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the head entry.
REQ-012 The module SHALL have ports out_x, out_y, out_ts and out_pol, outputs, with the same widths as the inputs, carrying the head entry fields.
REQ-013 The module SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-014 The module SHALL have port full, output, 1 bit: level==DEPTH.
REQ-015 The module SHALL have port drop_count, output, DROP_BITS bits: saturating count of discarded events.
REQ-016 The module SHALL have port overflow, output, 1 bit: sticky flag, set on first drop.

Function
REQ-017 The module SHALL store each entry as {ts, pol, y, x} in a DEPTH-entry circular buffer with separate write and read pointers and an occupancy counter.
REQ-018 The module SHALL make a push occur when in_valid=1 and (level<DEPTH or a pop occurs in the same cycle).
REQ-019 The module SHALL make a pop occur when out_valid=1 and out_ready=1.
REQ-020 The module SHALL keep in_valid push-only: it has no backpressure to the upstream receiver.
REQ-021 An event SHALL be dropped when in_valid=1, level==DEPTH and no pop occurs; a drop leaves stored contents and pointers unchanged.
REQ-022 On a drop, drop_count SHALL increment by 1, saturating at all-ones.
REQ-023 On a drop, overflow SHALL be set to 1 and stay 1 until reset.
REQ-024 The buffer SHALL be first-word-fall-through: out_valid = (level!=0), and out_* = entry at the read pointer, combinationally from storage.
REQ-025 Write latency SHALL be 1 cycle: an event pushed at edge N drives out_valid=1 after edge N when the FIFO was empty.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-027 level SHALL change by +1 on a push alone, -1 on a pop alone, and 0 on a simultaneous push and pop or when neither occurs.
REQ-028 Entries SHALL be popped in strict push order; no entry is duplicated or skipped.
REQ-029 While out_valid=1 and out_ready=0, out_* SHALL hold stable.
REQ-030 out_ready while empty SHALL have no effect.

Reset
REQ-031 While rst=1 at a clock edge, the module SHALL clear the pointers, set level=0, out_valid=0, full=0, drop_count=0 and overflow=0.
REQ-032 Storage contents SHALL NOT be reset; out_* SHALL be don't-care while out_valid=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries, and an in_valid in a reset cycle SHALL be ignored.
REQ-034 The first push after rst returns to 0 SHALL land at entry 0.

Verification
REQ-035 The bench SHALL cover single event: push x=5, y=7, ts=100, pol=1 into an empty FIFO -> next cycle out_valid=1, out fields 5/7/100/1, level=1; out_ready=1 for one cycle -> out_valid=0, level=0.
REQ-036 The bench SHALL cover fill and overflow: 18 pushes with out_ready=0 -> full=1, level=16, drop_count=2, overflow=1; draining returns events 1..16 in order.
REQ-037 The bench SHALL cover simultaneous push and pop when full: level stays 16, no drop, drop_count unchanged, and the new event appears after the 15 older ones.
REQ-038 The bench SHALL cover wrap-around: 40 push/pop pairs with out_ready=1 -> every event is returned in order with 1-cycle latency, and level never exceeds 1.
REQ-039 The bench SHALL cover reset mid-operation: with level=9 and overflow=1, pulse rst for 1 cycle alongside in_valid=1 -> level=0, out_valid=0, drop_count=0, overflow=0; the next push reads back correctly.
REQ-040 The bench SHALL cover saturation: with DROP_BITS=2, 5 drops -> drop_count=3.
